// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : iterative RV32M multiply/divide unit for the EX stage
// Rev 1.0
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  localparam int            CW   = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              done_q, done_d;

  // Results RISC-V defines without iterating: divide by zero and signed overflow
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign div_zero    = (rs2 == '0);
  assign div_ovf     = ~funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign special     = funct3[2] && (div_zero || div_ovf);
  assign special_res = div_zero ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : rs1);

  logic            sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  assign sgn_a = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
  assign sgn_b = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
  assign neg_a = sgn_a & a_q[XLEN-1];
  assign neg_b = sgn_b & b_q[XLEN-1];
  assign mag_a = neg_a ? -a_q : a_q;
  assign mag_b = neg_b ? -b_q : b_q;

  // Multiply keeps {partial, multiplier} in prod; divide keeps the dividend/quotient in its low half
  logic [XLEN:0] mul_sum, div_shift, div_trial;

  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign div_shift = {rem_q, prod_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, b_q};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  assign prod_fix = (sa_q ^ sb_q) ? -prod_q : prod_q;
  assign quo_fix  = (sa_q ^ sb_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
  assign rem_fix  = sa_q ? -rem_q : rem_q;

  always_comb begin
    fix_res = prod_fix[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:          fix_res = prod_fix[XLEN-1:0];
      3'b100, 3'b101:  fix_res = quo_fix;
      3'b110, 3'b111:  fix_res = rem_fix;
      default:         fix_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    result_d = result_q;
    prod_d   = prod_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d = funct3;
          a_d  = rs1;
          b_d  = rs2;
          if (special) begin
            result_d = special_res;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = PREP;
          end
        end
      end
      PREP: begin
        sa_d    = neg_a;
        sb_d    = neg_b;
        a_d     = mag_a;
        b_d     = mag_b;
        rem_d   = '0;
        prod_d  = op_q[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
        count_d = '0;
        state_d = CALC;
      end
      CALC: begin
        if (op_q[2]) begin
          rem_d              = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
          prod_d[XLEN-1:0]   = {prod_q[XLEN-2:0], ~div_trial[XLEN]};
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = fix_res;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect discards the operation without touching the visible result
    if (flush && (state_q != IDLE)) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      result_q <= '0;
      prod_q   <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      prod_q   <= prod_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);
  assign stall  = ((state_q == IDLE) && start && !flush) ||
                  (state_q == PREP) || (state_q == CALC) || (state_q == FIX);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer : scoreboard bench for muldiv_sequencer
// Rev 1.0
// ============================================================================
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        stall;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .result (result),
    .done   (done),
    .busy   (busy),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_res = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.due));
        last_res = e.res;
      end
    end
  end

  // Issue one op; due = accept edge plus 34 more edges, or only the accept edge for special cases
  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit special);
    int   stalls = 0;
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    rs1    = a;
    rs2    = b;
    e.res  = exp;
    e.due  = cyc + (special ? 1 : 35);
    e.name = name;
    sb.push_back(e);
    #1 if (stall) stalls++;
    do begin
      @(negedge clk);
      if (waited == 0) begin
        funct3 = ~f;
        rs1    = $urandom;
        rs2    = $urandom;
        start  = !special;
      end
      if (waited == 3) start = 1'b0;
      #1;
      waited++;
      if (stall) stalls++;
    end while (sb.size() != 0 && waited < 60);
    start = 1'b0;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL %s_timeout: no done within 60 cycles, required done", name);
      sb.delete();
    end
    check({name, "_stall_cycles"}, 32'(stalls), special ? 32'd1 : 32'd35);
    @(negedge clk);
    #1 check({name, "_idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset  = 1'b1;
    start  = 1'b1;
    flush  = 1'b0;
    funct3 = 3'b000;
    rs1    = 32'h0;
    rs2    = 32'h0;
    #1;
    check("reset_result", result, 32'h0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_stall_follows_start", {31'b0, stall}, 32'd1);
    start = 1'b0;
    #1 check("reset_stall_idle", {31'b0, stall}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_op("mul",        3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    do_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    do_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("mulh_neg",   3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0);
    do_op("mulhu_small",3'b011, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 1'b0);
    do_op("div_neg",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    do_op("rem_neg",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
    do_op("div_negb",   3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    do_op("rem_negb",   3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_op("divu",       3'b101, 32'd100,       32'd7,         32'd14,        1'b0);
    do_op("remu",       3'b111, 32'd100,       32'd7,         32'd2,         1'b0);
    do_op("divu_max",   3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0);
    do_op("remu_max",   3'b111, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 1'b0);
    do_op("div_by0",    3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
    do_op("remu_by0",   3'b111, 32'd5,         32'd0,         32'd5,         1'b1);
    do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    do_op("divu_ref",   3'b101, 32'd1000,      32'd10,        32'd100,       1'b0);

    // Flush in the 10th CALC cycle: nothing pushed, so any done is flagged
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; rs1 = 32'd77; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1 check("flush_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    #1;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result_held", result, last_res);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    check("flush_result_later", result, last_res);

    // start together with flush in IDLE is refused
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
    #1 check("flush_start_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    #1 check("flush_start_busy", {31'b0, busy}, 32'd0);
    start = 1'b0; flush = 1'b0;

    // Reset in the middle of CALC clears everything at once
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_result", result, 32'h0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    last_res = 32'h0;
    repeat (40) @(negedge clk);

    // Back-to-back: start held through DONE, second op only after DONE->IDLE
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1 = 32'd5; rs2 = 32'd0;
    e.res = 32'hFFFF_FFFF; e.due = cyc + 1; e.name = "b2b_first";
    sb.push_back(e);
    @(negedge clk);
    funct3 = 3'b110; rs1 = 32'd9; rs2 = 32'd0;
    e.res = 32'd9; e.due = cyc + 2; e.name = "b2b_second";
    sb.push_back(e);
    @(negedge clk);
    #1 check("b2b_idle_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
